// File: rtl/mdsa_sched_pkg.sv
// Shared types and helpers for the MDSA sorter job scheduler.
// Holds the FSM state type, the default payload width and index sizing.
package mdsa_sched_pkg;

   localparam int DATA_W_DEF = 2048;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_BUSY,
      S_DELIVER
   } sched_state_t;

   // Width of a requester index; never below one bit.
   function automatic int gid_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mdsa_rr_arbiter.sv
// Combinational round-robin picker for the MDSA job scheduler.
// Ports: req (request vector), ptr (search start), valid/index (winner).
module mdsa_rr_arbiter
   import mdsa_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int GW   = gid_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GW-1:0]    ptr,
   output logic             valid,
   output logic [GW-1:0]    index
);

   logic [GW:0] pos;

   // Walk offsets from far to near so the nearest set request at or
   // after ptr (wrapping) is the last, and therefore winning, write.
   always_comb begin
      valid = 1'b0;
      index = '0;
      pos   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (GW+1)'(k);
         if (pos >= (GW+1)'(N_REQ)) begin
            pos = pos - (GW+1)'(N_REQ);
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (pos == (GW+1)'(i))) begin
               valid = 1'b1;
               index = GW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/mdsa_job_scheduler.sv
// Shares one MDSA bitonic sorter between N_REQ requesters, one job at a time.
// Ports: req/req_data in, done/res_data/res_err out, srt_* to/from sorter.
module mdsa_job_scheduler
   import mdsa_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 4096,
   localparam int GW         = gid_w(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        done,
   output logic [DATA_W-1:0]       res_data,
   output logic                    res_err,
   output logic                    busy,
   output logic [GW-1:0]           grant_id,
   output logic                    srt_start,
   output logic                    srt_en,
   output logic [DATA_W-1:0]       srt_data_in,
   input  logic                    srt_rdy,
   input  logic                    srt_output_enable,
   input  logic [DATA_W-1:0]       srt_data_out
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   sched_state_t       state;
   sched_state_t       state_nx;
   logic [GW-1:0]      ptr;
   logic [CNT_W-1:0]   cnt;
   logic               arb_valid;
   logic [GW-1:0]      arb_idx;
   logic               take;
   logic               to_hit;
   logic [DATA_W-1:0]  win_data;
   logic [GW-1:0]      ptr_nx;

   mdsa_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .valid (arb_valid),
      .index (arb_idx)
   );

   // Watchdog fires on the last allowed BUSY cycle; 0 disables it.
   assign to_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

   assign ptr_nx = (grant_id == GW'(N_REQ - 1)) ? '0
                                                : grant_id + GW'(1);

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_idx == GW'(i)) begin
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      take      = 1'b0;
      srt_start = 1'b0;
      srt_en    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (arb_valid && srt_rdy) begin
               take     = 1'b1;
               state_nx = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            srt_start = 1'b1;
            srt_en    = 1'b1;
            state_nx  = S_BUSY;
         end
         S_BUSY: begin
            srt_en = 1'b1;
            if (srt_output_enable || to_hit) begin
               state_nx = S_DELIVER;
            end
         end
         S_DELIVER: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // done is decoded from state so an async reset kills it at once.
   always_comb begin
      done = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if ((state == S_DELIVER) && (grant_id == GW'(i))) begin
            done[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr         <= '0;
         grant_id    <= '0;
         srt_data_in <= '0;
         res_data    <= '0;
         res_err     <= 1'b0;
         busy        <= 1'b0;
         cnt         <= '0;
      end else begin
         if (take) begin
            grant_id    <= arb_idx;
            srt_data_in <= win_data;
            busy        <= 1'b1;
         end
         if (state == S_LAUNCH) begin
            cnt <= '0;
         end
         if (state == S_BUSY) begin
            cnt <= cnt + CNT_W'(1);
            // A completion on the watchdog cycle still counts as success.
            if (srt_output_enable) begin
               res_data <= srt_data_out;
               res_err  <= 1'b0;
            end else if (to_hit) begin
               res_err <= 1'b1;
            end
         end
         if (state == S_DELIVER) begin
            ptr  <= ptr_nx;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mdsa_job_scheduler.sv
// Directed self-checking bench for mdsa_job_scheduler.
// Drives requesters and a scripted sorter, compares against hand values.
module tb_mdsa_job_scheduler;

   localparam int N  = 4;
   localparam int DW = 2048;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    done;
   logic [DW-1:0]   res_data;
   logic            res_err;
   logic            busy;
   logic [1:0]      grant_id;
   logic            srt_start;
   logic            srt_en;
   logic [DW-1:0]   srt_data_in;
   logic            srt_rdy = 1'b1;
   logic            srt_oe  = 1'b0;
   logic [DW-1:0]   srt_dout = '0;

   int n_chk = 0;
   int n_err = 0;

   mdsa_job_scheduler #(
      .N_REQ       (N),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req               (req),
      .req_data          (req_data),
      .done              (done),
      .res_data          (res_data),
      .res_err           (res_err),
      .busy              (busy),
      .grant_id          (grant_id),
      .srt_start         (srt_start),
      .srt_en            (srt_en),
      .srt_data_in       (srt_data_in),
      .srt_rdy           (srt_rdy),
      .srt_output_enable (srt_oe),
      .srt_data_out      (srt_dout)
   );

   always #5 clk = ~clk;

   // Requester r holds words (r<<8)|(63-i): strictly descending.
   function automatic logic [DW-1:0] desc_pl(input int r);
      logic [DW-1:0] v;
      for (int i = 0; i < 64; i++) v[i*32 +: 32] = 32'((r << 8) | (63 - i));
      return v;
   endfunction

   function automatic logic [DW-1:0] asc_pl(input int r);
      logic [DW-1:0] v;
      for (int i = 0; i < 64; i++) v[i*32 +: 32] = 32'((r << 8) | i);
      return v;
   endfunction

   // Behavioural sorter: ascending 32-bit words, word 0 in the LSBs.
   function automatic logic [DW-1:0] sort_w(input logic [DW-1:0] v);
      logic [31:0]   w [64];
      logic [31:0]   t;
      logic [DW-1:0] r;
      for (int i = 0; i < 64; i++) w[i] = v[i*32 +: 32];
      for (int i = 0; i < 63; i++)
         for (int j = 0; j < 63 - i; j++)
            if (w[j] > w[j+1]) begin
               t = w[j]; w[j] = w[j+1]; w[j+1] = t;
            end
      for (int i = 0; i < 64; i++) r[i*32 +: 32] = w[i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (low 128b)", tag,
                  got[127:0], exp[127:0]);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Entered in an IDLE cycle with req already set; returns in next IDLE.
   task automatic job(input int id, input int lat, input logic [N-1:0] clr);
      logic [N-1:0] oh;
      oh = '0;
      oh[id] = 1'b1;
      tick;
      chk("start", DW'(srt_start), DW'(1));
      chk("grant", DW'(grant_id), DW'(id));
      chk("din", srt_data_in, desc_pl(id));
      chk("busy_launch", DW'(busy), DW'(1));
      repeat (lat) tick;
      chk("en_busy", DW'(srt_en), DW'(1));
      chk("done_early", DW'(done), DW'(0));
      srt_oe   = 1'b1;
      srt_dout = sort_w(srt_data_in);
      tick;
      srt_oe = 1'b0;
      chk("done", DW'(done), DW'(oh));
      chk("res", res_data, asc_pl(id));
      chk("err", DW'(res_err), DW'(0));
      chk("en_deliver", DW'(srt_en), DW'(0));
      req = req & ~clr;
      tick;
      chk("idle_busy", DW'(busy), DW'(0));
      chk("idle_done", DW'(done), DW'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1);
   end

   initial begin
      for (int r = 0; r < N; r++) req_data[r*DW +: DW] = desc_pl(r);
      #12;
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_res", res_data, DW'(0));
      chk("rst_err", DW'(res_err), DW'(0));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_gid", DW'(grant_id), DW'(0));
      chk("rst_start", DW'(srt_start), DW'(0));
      chk("rst_en", DW'(srt_en), DW'(0));
      chk("rst_din", srt_data_in, DW'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick;

      // Round-robin with all requesters held high.
      req = 4'b1111;
      for (int j = 0; j < 8; j++) job(j % 4, 4, '0);
      req = '0;
      tick;

      // Single job, 20-cycle sorter.
      req = 4'b0010;
      job(1, 20, 4'b0010);

      // Pointer skip: grant 2, then 0011 -> 0 then 1.
      req = 4'b0100;
      job(2, 3, 4'b0100);
      req = 4'b0011;
      job(0, 3, 4'b0001);
      job(1, 3, 4'b0010);

      // Timeout: sorter never completes.
      req = 4'b1000;
      tick;
      chk("to_start", DW'(srt_start), DW'(1));
      chk("to_grant", DW'(grant_id), DW'(3));
      repeat (TO) tick;
      chk("to_not_yet", DW'(done), DW'(0));
      chk("to_en", DW'(srt_en), DW'(1));
      tick;
      chk("to_done", DW'(done), DW'(4'b1000));
      chk("to_err", DW'(res_err), DW'(1));
      chk("to_res_held", res_data, asc_pl(1));
      req = '0;
      tick;

      // Backpressure then completion on the watchdog cycle.
      srt_rdy = 1'b0;
      req = 4'b0001;
      repeat (3) begin
         tick;
         chk("bp_start", DW'(srt_start), DW'(0));
         chk("bp_busy", DW'(busy), DW'(0));
      end
      srt_rdy = 1'b1;
      job(0, TO, 4'b0001);

      // Stray output_enable in IDLE is ignored.
      srt_oe   = 1'b1;
      srt_dout = '1;
      tick;
      srt_oe = 1'b0;
      chk("stray_res", res_data, asc_pl(0));
      chk("stray_busy", DW'(busy), DW'(0));
      chk("stray_start", DW'(srt_start), DW'(0));

      // Reset mid-BUSY.
      req = 4'b0010;
      tick;
      chk("mr_grant", DW'(grant_id), DW'(1));
      repeat (5) tick;
      chk("mr_en_pre", DW'(srt_en), DW'(1));
      rst = 1'b0;
      #1;
      chk("mr_en", DW'(srt_en), DW'(0));
      chk("mr_done", DW'(done), DW'(0));
      chk("mr_busy", DW'(busy), DW'(0));
      chk("mr_gid", DW'(grant_id), DW'(0));
      chk("mr_res", res_data, DW'(0));
      req = 4'b0100;
      tick;
      rst = 1'b1;
      job(2, 3, 4'b0100);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
